// File: rtl/ordener_2_if.sv
// Handshake/data bundle for the 8-input sorting network.
// master drives the unsorted set; slave returns the ordered set.
interface ordener_2_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic             out_valid;
  logic [WIDTH-1:0] s0, s1, s2, s3, s4, s5, s6, s7;

  modport master (
    output in_valid, a, b, c, d, e, f, g, h,
    input  out_valid, s0, s1, s2, s3, s4, s5, s6, s7
  );

  modport slave (
    input  in_valid, a, b, c, d, e, f, g, h,
    output out_valid, s0, s1, s2, s3, s4, s5, s6, s7
  );
endinterface

// File: rtl/ordener_2.sv
// Pipelined 8-lane odd-even transposition sorter, ascending (s0 = min).
// Two comparator layers per stage, four register stages, one set per clock.
module ordener_2 #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  ordener_2_if.slave bus
);
  localparam int LANES  = 8;
  localparam int STAGES = 4;

  typedef logic [WIDTH-1:0] laneArr_t [LANES];

  laneArr_t          w_inLanes;
  laneArr_t          w_next  [STAGES];
  laneArr_t          r_stage [STAGES];
  logic [STAGES-1:0] r_valid;

  // One odd layer (0-1,2-3,4-5,6-7) followed by one even layer (1-2,3-4,5-6).
  function automatic laneArr_t twoLayers(input laneArr_t x);
    laneArr_t         t;
    logic [WIDTH-1:0] tmp;
    t = x;
    for (int i = 0; i < LANES; i += 2) begin
      if (t[i] > t[i+1]) begin
        tmp    = t[i];
        t[i]   = t[i+1];
        t[i+1] = tmp;
      end
    end
    for (int i = 1; i < LANES - 1; i += 2) begin
      if (t[i] > t[i+1]) begin
        tmp    = t[i];
        t[i]   = t[i+1];
        t[i+1] = tmp;
      end
    end
    return t;
  endfunction

  assign w_inLanes[0] = bus.a;
  assign w_inLanes[1] = bus.b;
  assign w_inLanes[2] = bus.c;
  assign w_inLanes[3] = bus.d;
  assign w_inLanes[4] = bus.e;
  assign w_inLanes[5] = bus.f;
  assign w_inLanes[6] = bus.g;
  assign w_inLanes[7] = bus.h;

  // Stage 1 sorts straight from the input ports; later stages from the previous bank.
  always_comb begin
    w_next[0] = twoLayers(w_inLanes);
    for (int s = 1; s < STAGES; s++) begin
      w_next[s] = twoLayers(r_stage[s-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        for (int k = 0; k < LANES; k++) begin
          r_stage[s][k] <= '0;
        end
      end
      r_valid <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        r_stage[s] <= w_next[s];
      end
      r_valid <= {r_valid[STAGES-2:0], bus.in_valid};
    end
  end

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.s0 = r_stage[STAGES-1][0];
  assign bus.s1 = r_stage[STAGES-1][1];
  assign bus.s2 = r_stage[STAGES-1][2];
  assign bus.s3 = r_stage[STAGES-1][3];
  assign bus.s4 = r_stage[STAGES-1][4];
  assign bus.s5 = r_stage[STAGES-1][5];
  assign bus.s6 = r_stage[STAGES-1][6];
  assign bus.s7 = r_stage[STAGES-1][7];
endmodule

// File: tb/tb_ordener_2.sv
// Self-checking bench for ordener_2: a reference insertion sort feeds a
// 4-deep scoreboard that is compared against the DUT every cycle.
module tb_ordener_2;
  localparam int WIDTH   = 8;
  localparam int LATENCY = 4;

  typedef struct packed {
    logic        v;
    logic [63:0] d;
  } exp_t;

  logic clk;
  logic rst;
  int   vecCount;
  int   errCount;
  exp_t sb[$];

  ordener_2_if #(.WIDTH(WIDTH)) bus ();

  ordener_2 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs lanes a..h as bits [7:0]..[63:56].
  function automatic logic [63:0] mk(input logic [7:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction

  function automatic logic [63:0] refSort(input logic [63:0] in);
    logic [7:0] v [8];
    logic [7:0] key;
    int         j;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) v[i] = in[8*i +: 8];
    for (int i = 1; i < 8; i++) begin
      key = v[i];
      j = i - 1;
      while (j >= 0 && v[j] > key) begin
        v[j+1] = v[j];
        j--;
      end
      v[j+1] = key;
    end
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[i];
    return r;
  endfunction

  function automatic logic [63:0] outWord();
    return {bus.s7, bus.s6, bus.s5, bus.s4, bus.s3, bus.s2, bus.s1, bus.s0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic prefill();
    sb.delete();
    for (int i = 0; i < LATENCY; i++) sb.push_back('0);
  endtask

  // Compare the set driven LATENCY cycles ago, then drive and record a new set.
  task automatic applyStimulus(input string tag, input logic v, input logic [63:0] in);
    exp_t ex;
    @(negedge clk);
    ex = sb.pop_front();
    checkOutput({tag, "_valid"}, {63'd0, bus.out_valid}, {63'd0, ex.v});
    checkOutput({tag, "_data"}, outWord(), ex.d);
    bus.in_valid = v;
    {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = in;
    sb.push_back({v, refSort(in)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus("idle", 1'b0, 64'd0);
  endtask

  logic [63:0] basicSet, extremeSet, reverseSet, sortedSet, rnd;

  initial begin
    vecCount = 0;
    errCount = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = '0;
    basicSet   = mk(8'd1, 8'd2, 8'd12, 8'd8, 8'd4, 8'd10, 8'd6, 8'd3);
    extremeSet = mk(8'd255, 8'd0, 8'd7, 8'd7, 8'd128, 8'd0, 8'd255, 8'd1);
    reverseSet = mk(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1);
    sortedSet  = mk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);

    repeat (2) @(negedge clk);
    checkOutput("reset_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("reset_data", outWord(), 64'd0);
    rst = 1'b0;
    prefill();

    idle(3);
    applyStimulus("basic", 1'b1, basicSet);
    idle(5);
    checkOutput("basic_ref", refSort(basicSet), {8'd12, 8'd10, 8'd8, 8'd6, 8'd4, 8'd3, 8'd2, 8'd1});
    applyStimulus("extreme", 1'b1, extremeSet);
    idle(5);
    checkOutput("extreme_ref", refSort(extremeSet), {8'd255, 8'd255, 8'd128, 8'd7, 8'd7, 8'd1, 8'd0, 8'd0});
    applyStimulus("reverse", 1'b1, reverseSet);
    applyStimulus("sorted", 1'b1, sortedSet);
    applyStimulus("equal", 1'b1, {8{8'h5A}});
    idle(5);

    applyStimulus("b2b", 1'b1, basicSet);
    applyStimulus("b2b", 1'b1, extremeSet);
    applyStimulus("b2b", 1'b1, reverseSet);
    idle(5);

    // Asynchronous reset with the pipeline full, checked before any clock edge.
    for (int i = 0; i < 4; i++) applyStimulus("fill", 1'b1, {$urandom, $urandom});
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("async_rst_data", outWord(), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = '0;
    rst = 1'b0;
    prefill();
    idle(6);

    for (int i = 0; i < 1000; i++) begin
      rnd = {$urandom, $urandom};
      if ((i % 7) == 3) rnd[8*($urandom_range(0, 7)) +: 8] = 8'hFF;
      if ((i % 5) == 1) rnd[8*($urandom_range(0, 7)) +: 8] = 8'h00;
      applyStimulus("soak", 1'($urandom_range(0, 1)), rnd);
    end
    idle(LATENCY + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end
endmodule

// File: doc/ordener_2.md
Name: ordener_2

Overview:
- Pipelined 8-input sorting network. Takes eight unsigned words (a..h) and presents them on s0..s7 in ascending order, so s0 is the minimum and s7 the maximum.
- Used as a value-ordering/filtering stage in the datapath.
- Fully pipelined: accepts one new input set every clock, and outputs are registered.

Parameters:
- WIDTH, 8, bit width of every data input and output; comparisons are unsigned.

Ports:
- clk  input  1  single system clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a..h in the current cycle.
- a  input  WIDTH  data word 0
- b  input  WIDTH  data word 1
- c  input  WIDTH  data word 2
- d  input  WIDTH  data word 3
- e  input  WIDTH  data word 4
- f  input  WIDTH  data word 5
- g  input  WIDTH  data word 6
- h  input  WIDTH  data word 7
- out_valid  output  1  s0..s7 hold a sorted result.
- s0  output  WIDTH  smallest value
- s1  output  WIDTH  2nd smallest
- s2  output  WIDTH  3rd smallest
- s3  output  WIDTH  4th smallest
- s4  output  WIDTH  5th smallest
- s5  output  WIDTH  6th smallest
- s6  output  WIDTH  7th smallest
- s7  output  WIDTH  largest value

Interface decision: one clock; reset is asynchronous and active-high (ports clk, rst).

Behaviour:
- Network: odd-even transposition sort, 8 comparator layers on lanes L0..L7 (L0=a ... L7=h).
  - Odd layers 1,3,5,7 compare-exchange pairs (0,1),(2,3),(4,5),(6,7).
  - Even layers 2,4,6,8 compare-exchange pairs (1,2),(3,4),(5,6); L0 and L7 pass through.
- Compare-exchange(i,j), i<j: lane i gets min(Li,Lj), lane j gets max(Li,Lj). Comparison is unsigned, WIDTH bits. Equal values pass unchanged, and no width growth occurs.
- Pipelining: a register bank follows layers 2, 4, 6 and 8, giving 4 stages.
  - Latency is exactly 4 clocks from the edge sampling a..h/in_valid to s0..s7/out_valid.
  - Throughput is 1 set/clock.
- Stage 1 captures the layer-1/2 result of a..h combinationally from the inputs; the inputs themselves are not registered first.
- in_valid travels down a 4-bit valid shift chain alongside the data; out_valid is the last bit.
- Data registers load every cycle regardless of in_valid (no enable gating). s0..s7 are meaningful only when out_valid=1.
- No backpressure: the consumer must accept results in the cycle out_valid is high.
- Reset, asserted at any time including mid-stream:
  - All data pipeline registers go to 0, so s0..s7 = 0 immediately.
  - All valid bits go to 0, so out_valid = 0 immediately.
  - In-flight sets are discarded.
- After rst deasserts, the first out_valid appears 4 clocks after the first in_valid sampled high.
- Boundary conditions:
  - All inputs equal: outputs all equal that value.
  - Already sorted or reverse-sorted inputs: output is ascending.
  - Values 0 and 2^WIDTH-1 sort correctly as unsigned (e.g. 8'hFF goes to s7, never treated as negative).
- The output multiset always equals the input multiset: it is a permutation, with no duplication or loss.
- Output ordering invariant: s0<=s1<=...<=s7 for every valid result.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle with the pipeline full -> s0..s7=0 and out_valid=0 immediately, with no clock edge needed. After release, idle inputs give out_valid=0.
- Basic sort: a..h = 1,2,12,8,4,10,6,3 with in_valid=1 for one cycle -> 4 clocks later out_valid=1 and s0..s7 = 1,2,3,4,6,8,10,12. out_valid=0 on the next cycle.
- Extremes and duplicates: a..h = 255,0,7,7,128,0,255,1 -> s0..s7 = 0,0,1,7,7,128,255,255.
- Reverse-sorted and sorted: a..h = 8,7,6,5,4,3,2,1 -> s0..s7 = 1..8. a..h = 1..8 -> the same output.
- Back-to-back throughput: drive the basic-sort set, then the extremes set, then the reverse set on consecutive cycles with in_valid=1 -> three consecutive out_valid cycles, each in the correct order, with no bubbles.
- Random soak: 1000 random sets with random in_valid -> each output equals a reference sort of the input sampled 4 cycles earlier, and out_valid matches delayed in_valid.
